// File: rtl/sfp_link_sequencer.sv
// Master/slave transaction sequencer between the AXI4-Lite register block and the
// Aurora SFP AXIS frame IP: launch/retry/timeout as master, slot extract/insert as slave.
module sfp_link_sequencer #(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int C_NUMBER_OF_SLAVE  = 3,
    parameter int C_NUMBER_OF_FRAME  = 1,
    parameter int C_TIMEOUT_CYCLES   = 1000,
    parameter int C_MAX_RETRY        = 2,
    parameter int C_CNT_WIDTH        = 16,
    parameter int C_ID_WIDTH         = 4,
    parameter int C_DATA_FRAME_BIT   = C_AXIS_TDATA_WIDTH * C_NUMBER_OF_FRAME,
    parameter int C_DATA_BIT         = C_DATA_FRAME_BIT * C_NUMBER_OF_SLAVE
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_mode,
    input  logic [C_ID_WIDTH-1:0]       i_slave_id,
    input  logic                        i_start,
    input  logic [C_DATA_BIT-1:0]       i_tx_stream_data,
    output logic [C_DATA_BIT-1:0]       o_tx_stream_data,
    output logic                        o_tx_start_flag,
    input  logic                        i_rx_end_flag,
    input  logic [C_DATA_BIT-1:0]       i_rx_stream_data,
    output logic [C_DATA_BIT-1:0]       o_rx_stream_data,
    output logic                        o_stream_valid,
    input  logic                        i_stream_valid_clr,
    output logic [C_DATA_FRAME_BIT-1:0] o_frame_data,
    output logic                        o_frame_valid,
    input  logic [C_DATA_FRAME_BIT-1:0] i_frame_data,
    input  logic                        i_frame_ack,
    output logic                        o_busy,
    output logic                        o_timeout_err,
    output logic [3:0]                  o_retry_cnt,
    output logic [C_CNT_WIDTH-1:0]      o_tx_cnt,
    output logic [C_CNT_WIDTH-1:0]      o_rx_cnt,
    output logic [3:0]                  o_state
);

    localparam int C_TIMER_W = (C_TIMEOUT_CYCLES > 2) ? $clog2(C_TIMEOUT_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        M_SEND     = 4'd1,
        M_WAIT     = 4'd2,
        M_DONE     = 4'd3,
        S_WAIT_ACK = 4'd4,
        S_SEND     = 4'd5,
        ERROR      = 4'd6
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [C_TIMER_W-1:0] timer;
    logic                 timer_done;
    logic                 retry_left;
    logic                 id_in_range;

    assign timer_done  = (timer == C_TIMER_W'(C_TIMEOUT_CYCLES - 1));
    assign retry_left  = (o_retry_cnt < 4'(C_MAX_RETRY));
    assign id_in_range = (32'(i_slave_id) < 32'(C_NUMBER_OF_SLAVE));

    assign o_tx_start_flag = (state == M_SEND) || (state == S_SEND);
    assign o_busy          = (state != IDLE);
    assign o_state         = state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An end flag in M_WAIT takes priority over a coincident timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!i_mode && i_start) begin
                    state_nxt = M_SEND;
                end else if (i_mode && i_rx_end_flag) begin
                    state_nxt = S_WAIT_ACK;
                end
            end
            M_SEND: state_nxt = M_WAIT;
            M_WAIT: begin
                if (i_rx_end_flag) begin
                    state_nxt = M_DONE;
                end else if (timer_done) begin
                    state_nxt = retry_left ? M_SEND : ERROR;
                end
            end
            M_DONE:     if (i_stream_valid_clr) state_nxt = IDLE;
            ERROR:      if (i_stream_valid_clr) state_nxt = IDLE;
            S_WAIT_ACK: if (i_frame_ack) state_nxt = S_SEND;
            S_SEND:     state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tx_stream_data <= '0;
            o_rx_stream_data <= '0;
            o_stream_valid   <= 1'b0;
            o_frame_data     <= '0;
            o_frame_valid    <= 1'b0;
            o_timeout_err    <= 1'b0;
            o_retry_cnt      <= '0;
            o_tx_cnt         <= '0;
            o_rx_cnt         <= '0;
            timer            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_mode && i_start) begin
                        o_tx_stream_data <= i_tx_stream_data;
                        o_retry_cnt      <= '0;
                    end else if (i_mode && i_rx_end_flag) begin
                        o_tx_stream_data <= i_rx_stream_data;
                        o_frame_valid    <= 1'b1;
                        o_rx_cnt         <= o_rx_cnt + 1'b1;
                        // Constant-index slot walk keeps an out-of-range id at zero.
                        o_frame_data     <= '0;
                        for (int unsigned k = 0; k < C_NUMBER_OF_SLAVE; k++) begin
                            if (32'(i_slave_id) == k) begin
                                o_frame_data <= i_rx_stream_data[k*C_DATA_FRAME_BIT +: C_DATA_FRAME_BIT];
                            end
                        end
                    end
                end
                M_SEND: begin
                    o_tx_cnt <= o_tx_cnt + 1'b1;
                    timer    <= '0;
                end
                M_WAIT: begin
                    timer <= timer + 1'b1;
                    if (i_rx_end_flag) begin
                        o_rx_stream_data <= i_rx_stream_data;
                        o_stream_valid   <= 1'b1;
                        o_rx_cnt         <= o_rx_cnt + 1'b1;
                    end else if (timer_done) begin
                        if (retry_left) begin
                            o_retry_cnt <= o_retry_cnt + 1'b1;
                        end else begin
                            o_timeout_err <= 1'b1;
                        end
                    end
                end
                M_DONE: begin
                    if (i_stream_valid_clr) o_stream_valid <= 1'b0;
                end
                ERROR: begin
                    if (i_stream_valid_clr) o_timeout_err <= 1'b0;
                end
                S_WAIT_ACK: begin
                    if (i_frame_ack) begin
                        o_frame_valid <= 1'b0;
                        if (id_in_range) begin
                            for (int unsigned k = 0; k < C_NUMBER_OF_SLAVE; k++) begin
                                if (32'(i_slave_id) == k) begin
                                    o_tx_stream_data[k*C_DATA_FRAME_BIT +: C_DATA_FRAME_BIT] <= i_frame_data;
                                end
                            end
                        end
                    end
                end
                S_SEND: begin
                    o_tx_cnt <= o_tx_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
